// File: rtl/adc_seq_pkg.sv
// Shared constants for the ADC frame sequencer: FSM state codes, channel
// count, sticky error bit positions and the frame FIFO entry width.
package adc_seq_pkg;

    localparam int NUM_CH = 4;

    // Sequencer state, 2-bit legacy-compatible encoding
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE    = 2'd0;
    localparam seq_state_t ST_ARMED   = 2'd1;
    localparam seq_state_t ST_COLLECT = 2'd2;
    localparam seq_state_t ST_COMMIT  = 2'd3;

    // Sticky error bit positions
    localparam int ERR_OVF  = 0;
    localparam int ERR_TMO  = 1;
    localparam int ERR_TRIG = 2;
    localparam int ERR_W    = 3;

    // One FIFO entry holds the captured-channel tag plus every channel slot
    function automatic int entry_width(input int data_w);
        return NUM_CH + NUM_CH * data_w;
    endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO. The head entry is held in
// a register so rdata is a flop output. A push while full with no pop is
// dropped (drop pulses); a push and pop together while full both succeed.
module adc_frame_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt,
    output logic                     empty,
    output logic                     full,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_nxt;

    assign empty      = (count == '0);
    assign full       = (count == LW'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign drop       = push && full && !do_pop;
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign level_nxt  = count + LW'(do_push) - LW'(do_pop);
    assign level      = count;

    // Select what the head register holds after this cycle's push/pop
    always_comb begin
        head_nxt = rdata;
        if (level_nxt == '0) begin
            head_nxt = '0;
        end else if (do_pop) begin
            // Popping the only entry: the simultaneous push becomes the head
            head_nxt = (count == LW'(1)) ? wdata : mem[rd_ptr_inc];
        end else if (empty && do_push) begin
            head_nxt = wdata;
        end
    end

    // Storage array write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= level_nxt;
            rdata <= head_nxt;
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// Gathers one result per enabled ADC channel into a coherent frame, either
// free-running or armed by the PWM carrier sync, guards collection with a
// timeout, and queues finished frames in a FWFT FIFO for the register block.
module adc_frame_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mode_trig,
    input  logic [NUM_CH-1:0]             ch_mask,
    input  logic                          trig_in,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]      ch_data,
    input  logic                          rd_en,
    output logic [NUM_CH*DATA_W-1:0]      rd_data,
    output logic [NUM_CH-1:0]             rd_tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    input  logic [$clog2(FIFO_DEPTH):0]   irq_thresh,
    output logic                          irq,
    output logic [ERR_W-1:0]              err,
    input  logic                          clr_err
);

    localparam int ENTRY_W = entry_width(DATA_W);
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;

    seq_state_t                 state;
    seq_state_t                 state_nxt;
    logic [NUM_CH-1:0]          active;
    logic [NUM_CH-1:0]          captured;
    logic [NUM_CH*DATA_W-1:0]   frame_data;
    logic [TW-1:0]              tmo_cnt;

    logic [NUM_CH-1:0]          hit;
    logic [NUM_CH-1:0]          cap_all;
    logic                       done;
    logic                       tmo_hit;
    logic                       enter_collect;
    logic                       tmo_evt;
    logic                       trig_evt;
    logic                       collecting;

    logic                       fifo_push;
    logic [ENTRY_W-1:0]         fifo_wdata;
    logic [ENTRY_W-1:0]         fifo_rdata;
    logic [LW-1:0]              level_nxt;
    logic                       fifo_drop;
    logic [ERR_W-1:0]           err_evt;

    // First result per channel wins; masked-off channels never register
    assign hit        = ch_valid & active & ~captured;
    assign cap_all    = captured | hit;
    assign done       = (cap_all == active);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign collecting = (state == ST_COLLECT) && enable;
    assign trig_evt   = (state == ST_COLLECT) && trig_in;

    // Next-state decode; also flags COLLECT entry and timeout commits
    always_comb begin
        state_nxt     = state;
        enter_collect = 1'b0;
        tmo_evt       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    if (mode_trig) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        state_nxt     = ST_COLLECT;
                        enter_collect = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (trig_in) begin
                    if (ch_mask != '0) begin
                        state_nxt     = ST_COLLECT;
                        enter_collect = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_COLLECT: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (done) begin
                    // Completion beats a coinciding timeout
                    state_nxt = ST_COMMIT;
                end else if (tmo_hit) begin
                    state_nxt = ST_COMMIT;
                    tmo_evt   = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (enable && (ch_mask != '0)) begin
                    if (mode_trig) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        state_nxt     = ST_COLLECT;
                        enter_collect = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture slots, captured tags, active mask and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            captured   <= '0;
            frame_data <= '0;
            tmo_cnt    <= '0;
        end else if (enter_collect) begin
            active     <= ch_mask;
            captured   <= '0;
            frame_data <= '0;
            tmo_cnt    <= '0;
        end else if (collecting) begin
            captured <= cap_all;
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    frame_data[i*DATA_W +: DATA_W] <= ch_data[i*DATA_W +: DATA_W];
                end
            end
            if (!done && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // Slots never written during the frame are still zero from COLLECT entry
    assign fifo_push  = (state == ST_COMMIT);
    assign fifo_wdata = {captured, frame_data};

    adc_frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .wdata     (fifo_wdata),
        .pop       (rd_en),
        .rdata     (fifo_rdata),
        .level     (fifo_level),
        .level_nxt (level_nxt),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign {rd_tag, rd_data} = fifo_rdata;

    assign err_evt[ERR_OVF]  = fifo_drop;
    assign err_evt[ERR_TMO]  = tmo_evt;
    assign err_evt[ERR_TRIG] = trig_evt;

    // Sticky errors; a new event in the clearing cycle survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= '0;
        end else begin
            err <= (clr_err ? '0 : err) | err_evt;
        end
    end

    // Level interrupt follows the post-update FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (irq_thresh != '0) && (level_nxt >= irq_thresh);
        end
    end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer. Expected frames go into a queue as
// stimulus creates them; a monitor pops and compares whenever a FIFO read
// actually happens.
module tb_adc_frame_sequencer;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mode_trig;
    logic [3:0]  ch_mask;
    logic        trig_in;
    logic [3:0]  ch_valid;
    logic [63:0] ch_data;
    logic        rd_en;
    logic [63:0] rd_data;
    logic [3:0]  rd_tag;
    logic [3:0]  fifo_level;
    logic        fifo_empty;
    logic        fifo_full;
    logic [3:0]  irq_thresh;
    logic        irq;
    logic [2:0]  err;
    logic        clr_err;

    int          checks = 0;
    int          errors = 0;
    logic [67:0] sb_q[$];
    int          exp_level = 0;

    adc_frame_sequencer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode_trig  (mode_trig),
        .ch_mask    (ch_mask),
        .trig_in    (trig_in),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_tag     (rd_tag),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .irq_thresh (irq_thresh),
        .irq        (irq),
        .err        (err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] d3, input logic [15:0] d2,
                                          input logic [15:0] d1, input logic [15:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Record an expected frame unless the model FIFO is already full
    task automatic expect_frame(input logic [3:0] tag, input logic [63:0] data);
        if (exp_level < FIFO_DEPTH) begin
            sb_q.push_back({tag, data});
            exp_level++;
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_level > 0) exp_level--;
    endtask

    // One single-channel continuous frame from IDLE back to IDLE
    task automatic send_frame_cont(input logic [15:0] d);
        mode_trig = 1'b0;
        ch_mask   = 4'h1;
        enable    = 1'b1;
        tick();
        ch_data  = pack4(16'h0, 16'h0, 16'h0, d);
        ch_valid = 4'h1;
        expect_frame(4'h1, pack4(16'h0, 16'h0, 16'h0, d));
        tick();
        ch_valid = 4'h0;
        enable   = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: compare the head whenever a real pop occurs
    always @(negedge clk) begin
        logic [67:0] exp_e;
        if (!rst && rd_en && !fifo_empty) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got tag 0x%0h data 0x%0h expected no frame", rd_tag, rd_data);
            end else begin
                exp_e = sb_q.pop_front();
                chk("sb_frame", {rd_tag, rd_data}, exp_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; mode_trig = 1'b0; ch_mask = 4'h0; trig_in = 1'b0;
        ch_valid = 4'h0; ch_data = '0; rd_en = 1'b0; irq_thresh = 4'h0; clr_err = 1'b0;
        tick(); tick();
        chk("rst_empty", 68'(fifo_empty), 68'(1));
        chk("rst_level", 68'(fifo_level), 68'(0));
        chk("rst_full",  68'(fifo_full),  68'(0));
        chk("rst_rd",    {rd_tag, rd_data}, 68'(0));
        chk("rst_irq",   68'(irq), 68'(0));
        chk("rst_err",   68'(err), 68'(0));
        rst = 1'b0;
        tick();

        // Continuous, all four channels, repeated ch0 strobe must be ignored
        mode_trig = 1'b0; ch_mask = 4'hF; enable = 1'b1;
        tick();
        ch_data = pack4(16'h0, 16'h0, 16'h0, 16'h1111); ch_valid = 4'h1; tick();
        ch_data = pack4(16'h0, 16'h0, 16'h2222, 16'h9999); ch_valid = 4'h3; tick();
        ch_data = pack4(16'h0, 16'h3333, 16'h0, 16'h0); ch_valid = 4'h4; tick();
        ch_data = pack4(16'h4444, 16'h0, 16'h0, 16'h0); ch_valid = 4'h8;
        expect_frame(4'hF, 64'h4444_3333_2222_1111);
        tick();
        ch_valid = 4'h0; enable = 1'b0;
        chk("lat_commit_empty", 68'(fifo_empty), 68'(1));
        tick();
        chk("lat_t2_empty", 68'(fifo_empty), 68'(0));
        chk("lat_t2_level", 68'(fifo_level), 68'(1));
        pop_one();
        chk("pop_empty", 68'(fifo_empty), 68'(1));
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("pop_when_empty_level", 68'(fifo_level), 68'(0));

        // Triggered, mask 5: pre-trigger strobes and late ch0 ignored
        mode_trig = 1'b1; ch_mask = 4'h5; enable = 1'b1;
        tick();
        ch_data = {4{16'hCCCC}}; ch_valid = 4'hF; tick();
        ch_valid = 4'h0; trig_in = 1'b1; tick();
        trig_in = 1'b0; ch_data = {4{16'hAAAA}}; ch_valid = 4'hF;
        expect_frame(4'h5, pack4(16'h0, 16'hAAAA, 16'h0, 16'hAAAA));
        tick();
        ch_data = pack4(16'h0, 16'h0, 16'h0, 16'hBBBB); ch_valid = 4'h1; enable = 1'b0;
        tick();
        ch_valid = 4'h0;
        chk("trig_level", 68'(fifo_level), 68'(1));
        pop_one();
        chk("trig_err", 68'(err), 68'(0));

        // Timeout with only ch0/ch1 arriving
        mode_trig = 1'b1; ch_mask = 4'hF; enable = 1'b1;
        tick();
        trig_in = 1'b1; tick();
        trig_in = 1'b0; n = 1;
        ch_data = pack4(16'h0, 16'h0, 16'h0202, 16'h0101); ch_valid = 4'h1;
        expect_frame(4'h3, pack4(16'h0, 16'h0, 16'h0202, 16'h0101));
        tick(); n++;
        ch_valid = 4'h2; tick(); n++;
        ch_valid = 4'h0;
        while (fifo_empty && n < 60) begin
            tick(); n++;
        end
        chk("tmo_cycle", 68'(n), 68'(22));
        chk("tmo_err", 68'(err), 68'(3'b010));
        enable = 1'b0; tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err", 68'(err), 68'(0));

        // Second trigger during COLLECT flags overrun; frame still completes
        enable = 1'b1; tick();
        trig_in = 1'b1; tick();
        trig_in = 1'b0; ch_data = pack4(16'h0, 16'h0, 16'h0222, 16'h0111); ch_valid = 4'h3; tick();
        ch_valid = 4'h0; trig_in = 1'b1; tick();
        trig_in = 1'b0; ch_data = pack4(16'h0404, 16'h0303, 16'h0, 16'h0); ch_valid = 4'hC;
        expect_frame(4'hF, 64'h0404_0303_0222_0111);
        tick();
        ch_valid = 4'h0; enable = 1'b0; tick();
        chk("trig_overrun_err", 68'(err), 68'(3'b100));
        chk("tmo_two_frames", 68'(fifo_level), 68'(2));
        pop_one(); pop_one();
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // irq threshold and overflow
        irq_thresh = 4'd3;
        send_frame_cont(16'h0100); send_frame_cont(16'h0101);
        chk("irq_lvl2", 68'(irq), 68'(0));
        send_frame_cont(16'h0102);
        chk("irq_lvl3", 68'(irq), 68'(1));
        pop_one();
        chk("irq_after_pop", 68'(irq), 68'(0));
        for (int k = 0; k < 6; k++) send_frame_cont(16'h0200 + 16'(k));
        chk("full_flag", 68'(fifo_full), 68'(1));
        chk("full_level", 68'(fifo_level), 68'(8));
        chk("full_no_ovf", 68'(err), 68'(0));
        send_frame_cont(16'hDEAD);
        chk("ovf_err", 68'(err), 68'(3'b001));
        chk("ovf_level", 68'(fifo_level), 68'(8));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        // Full FIFO with pop in the COMMIT cycle: both succeed
        mode_trig = 1'b0; ch_mask = 4'h1; enable = 1'b1; tick();
        ch_data = pack4(16'h0, 16'h0, 16'h0, 16'h7777); ch_valid = 4'h1; tick();
        sb_q.push_back({4'h1, pack4(16'h0, 16'h0, 16'h0, 16'h7777)});
        ch_valid = 4'h0; enable = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("pushpop_level", 68'(fifo_level), 68'(8));
        chk("pushpop_err", 68'(err), 68'(0));
        irq_thresh = 4'd0; tick();
        chk("irq_disabled", 68'(irq), 68'(0));
        for (int k = 0; k < 8; k++) pop_one();
        exp_level = 0;
        chk("drain_empty", 68'(fifo_empty), 68'(1));

        // Abort after two of four channels
        mode_trig = 1'b0; ch_mask = 4'hF; enable = 1'b1; tick();
        ch_data = pack4(16'h0, 16'h0, 16'h5252, 16'h5151); ch_valid = 4'h1; tick();
        ch_valid = 4'h2; tick();
        ch_valid = 4'h0; enable = 1'b0; tick();
        ch_valid = 4'hF; tick(); tick();
        ch_valid = 4'h0; tick();
        chk("abort_empty", 68'(fifo_empty), 68'(1));
        chk("abort_level", 68'(fifo_level), 68'(0));

        // Asynchronous reset with a partly filled FIFO and pending errors
        irq_thresh = 4'd3;
        for (int k = 0; k < 5; k++) send_frame_cont(16'h0300 + 16'(k));
        chk("pre_rst_level", 68'(fifo_level), 68'(5));
        chk("pre_rst_irq", 68'(irq), 68'(1));
        mode_trig = 1'b0; ch_mask = 4'hF; enable = 1'b1; tick();
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        chk("pre_rst_err", 68'(err), 68'(3'b100));
        rst = 1'b1;
        #2;
        chk("async_rst_level", 68'(fifo_level), 68'(0));
        chk("async_rst_empty", 68'(fifo_empty), 68'(1));
        chk("async_rst_err", 68'(err), 68'(0));
        chk("async_rst_irq", 68'(irq), 68'(0));
        chk("async_rst_rd", {rd_tag, rd_data}, 68'(0));
        sb_q.delete();
        exp_level = 0;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_empty", 68'(fifo_empty), 68'(1));
        chk("sb_drained", 68'(sb_q.size()), 68'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Sequences the 4-channel sigma-delta ADC results into coherent sample frames for the CPU and control loop. In triggered mode, a PWM carrier sync pulse arms the sequencer. In continuous mode it free-runs. It collects one result per enabled channel, with a timeout guard, and pushes each completed frame into a small FWFT frame FIFO. Sits between the ADC channel outputs and the Wishbone register block; the register block drives the configuration inputs and the FIFO read port.

Parameters:
DATA_W, 16, width of one channel result
FIFO_DEPTH, 8, frame FIFO entries; power of two, minimum 2
TIMEOUT, 5000, max clk cycles spent in COLLECT (100 us at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous active-high reset
enable  in  1  sequencer run enable
mode_trig  in  1  1 = wait for trig_in per frame; 0 = continuous
ch_mask  in  4  channels required in a frame
trig_in  in  1  single-cycle PWM sync pulse
ch_valid  in  4  per-channel result strobe from ADC channels
ch_data  in  4*DATA_W  packed results, ch0 in LSBs
rd_en  in  1  pop FIFO head
rd_data  out  4*DATA_W  FIFO head frame data
rd_tag  out  4  FIFO head: channels actually captured
fifo_level  out  log2(FIFO_DEPTH)+1  entries held
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
irq_thresh  in  log2(FIFO_DEPTH)+1  irq level; 0 disables irq
irq  out  1  level interrupt
err  out  3  sticky errors: [0] overflow, [1] timeout, [2] trig_overrun
clr_err  in  1  clear err bits

Behaviour:
- Reset:
  - state IDLE, FIFO empty, fifo_level 0, fifo_empty 1, fifo_full 0.
  - rd_data 0, rd_tag 0, irq 0, err 0.
  - Internal capture registers and timeout counter are cleared.
- States: IDLE, ARMED, COLLECT, COMMIT.
- IDLE:
  - enable=1 and ch_mask!=0 -> ARMED if mode_trig, else COLLECT.
  - ch_mask==0 keeps IDLE.
- ARMED: trig_in=1 -> COLLECT; enable=0 -> IDLE.
- Entry to COLLECT:
  - latch ch_mask into an active mask;
  - clear captured[3:0] and frame data;
  - timeout counter := 0.
- COLLECT, each cycle:
  - For each i with ch_valid[i] & active[i] & !captured[i]: latch data into slot i and set captured[i].
  - Strobes on an already-captured channel or a masked-off channel are ignored (first result wins).
  - Completion: captured|new == active -> COMMIT next cycle.
  - Timeout: counter reaches TIMEOUT-1 without completion -> COMMIT with a partial frame; set err[1].
  - If completion and timeout occur in the same cycle, completion wins and no error is flagged.
  - trig_in=1 while in COLLECT sets err[2]; the trigger is not queued.
  - enable=0: abort, discard the partial frame, IDLE next cycle.
- COMMIT (one cycle):
  - Push {captured, data}; missing slots push 0.
  - Exit: if enable, go to ARMED (triggered) or COLLECT (continuous, new frame begins); otherwise IDLE.
  - The ch_mask change takes effect at the next COLLECT entry only.
- Latency: last required ch_valid at cycle t -> COMMIT at t+1 -> fifo_empty=0, with rd_data/rd_tag valid, at t+2.
- FIFO:
  - Synchronous, FWFT; rd_data/rd_tag are registered head outputs.
  - rd_en while empty is ignored.
  - Push while full with no pop: frame dropped, err[0] set, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- irq: registered; irq = (irq_thresh!=0) && (fifo_level >= irq_thresh), evaluated on the updated level.
- err: each bit sticky until clr_err. If clr_err and a new error event coincide, the set wins.
- Reset mid-operation (any state, FIFO non-empty) returns everything to reset values asynchronously.

Decomposition:
- Package adc_seq_pkg:
  - state enum encoding (2-bit);
  - NUM_CH=4;
  - err bit index constants (ERR_OVF=0, ERR_TMO=1, ERR_TRIG=2);
  - FIFO entry width = 4 + 4*DATA_W.
- Sub-module adc_frame_fifo: parameterised FWFT synchronous FIFO exposing level/full/empty and the push-while-full drop rule.
- The sequencer FSM, capture registers, timeout counter, irq and err logic live in the top.

Test Plan:
- Continuous, mask=4'hF: ch_valid pulses 1,2,4,8 on separate cycles with data 0x1111/0x2222/0x3333/0x4444 -> one frame, rd_tag=F, rd_data=0x4444_3333_2222_1111, fifo_empty falls 2 cycles after the last strobe.
- Triggered, mask=4'h5: strobes before trig_in are ignored. trig_in, then ch_valid=4'hF data 0xAAAA each, then ch0 again 0xBBBB -> rd_tag=5, slots 0/2=0xAAAA, slots 1/3=0, second ch0 strobe ignored.
- Timeout (TIMEOUT=20 in bench), mask=F, only ch0/ch1 arrive -> frame pushed at cycle 20 of COLLECT with rd_tag=3, err=3'b010. clr_err clears it. A second trig_in mid-COLLECT sets err[2].
- Overflow: FIFO_DEPTH=8, no reads, 9 complete frames -> fifo_full=1, level 8, err[0]=1, the 9th frame is dropped. With full FIFO plus rd_en during a COMMIT, level stays 8 and the new frame is at the tail.
- irq_thresh=3: 2 frames -> irq 0; 3rd -> irq 1; one pop -> irq 0. irq_thresh=0 keeps irq 0 with a full FIFO.
- Abort: enable=0 after 2 of 4 channels are captured -> nothing pushed, state IDLE. Assert rst with FIFO level 5 -> level 0, err 0, irq 0 immediately.
